// File: rtl/icsp_program_loader_pkg.sv
// Shared opcodes, frame lengths and FSM states for the ICSP loader.
// ST_ERASE only exists when ICSP_BULK_ERASE_EN is defined.
package icsp_program_loader_pkg;

  localparam int CMD_BITS   = 6;
  localparam int FRAME_BITS = 16;

  localparam logic [5:0] CMD_LOAD       = 6'h02;
  localparam logic [5:0] CMD_READ       = 6'h04;
  localparam logic [5:0] CMD_INCR       = 6'h06;
  localparam logic [5:0] CMD_PROG       = 6'h08;
  localparam logic [5:0] CMD_BULK_ERASE = 6'h09;
  localparam logic [5:0] CMD_RESET_ADDR = 6'h16;

  localparam logic [13:0] ERASE_FILL = 14'h3FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LOAD_DATA,
    ST_READ_FETCH,
    ST_READ_CAPTURE,
    ST_READ_SHIFT,
    ST_PROG
`ifdef ICSP_BULK_ERASE_EN
    , ST_ERASE
`endif
  } state_e;

endpackage

// File: rtl/icsp_program_loader_sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses
// taken on the synchronised level.
module icsp_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/icsp_program_loader.sv
// ICSP serial programming responder driving the program memory port.
// Define ICSP_BULK_ERASE_EN to add the 0x09 bulk-erase command.
module icsp_program_loader
  import icsp_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 14,
  parameter int SYNC_STAGES = 2,
  parameter int PROG_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_mode,
  input  logic                  icsp_clk,
  input  logic                  icsp_dat_in,
  output logic                  icsp_dat_out,
  output logic                  icsp_dat_oe,
  output logic                  core_hold,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic                  pm_wr_en,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  pm_rd_en,
  input  logic [DATA_WIDTH-1:0] pm_rd_data,
  output logic                  busy
);

  localparam int CNT_MAX =
    (PROG_CYCLES > FRAME_BITS) ? PROG_CYCLES : FRAME_BITS;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  logic mode_s, clk_s, dat_s;
  logic clk_rise, clk_fall;
  logic clk_s_unused;
  logic dat_rise_unused, dat_fall_unused;
  logic mode_rise_unused, mode_fall_unused;

  icsp_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(icsp_clk),
    .q_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  icsp_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst(rst), .d_i(icsp_dat_in),
    .q_o(dat_s), .rise_o(dat_rise_unused),
    .fall_o(dat_fall_unused)
  );

  icsp_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(clk), .rst(rst), .d_i(prog_mode),
    .q_o(mode_s), .rise_o(mode_rise_unused),
    .fall_o(mode_fall_unused)
  );

  assign clk_s_unused = clk_s;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] latch_q, latch_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic                  oe_q, oe_d;
  logic                  dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic                  hold_q;

  logic [FRAME_BITS-1:0] nxt;
  logic [CMD_BITS-1:0]   cmd;

  assign nxt = {dat_s, shift_q[FRAME_BITS-1:1]};
  assign cmd = nxt[FRAME_BITS-1 -: CMD_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      latch_q   <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      latch_q   <= latch_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      hold_q    <= mode_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    latch_d   = latch_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    rd_en_d   = 1'b0;
    oe_d      = oe_q;
    dout_d    = dout_q;
    busy_d    = busy_q;

    // Dropping prog_mode abandons everything except the latch.
    if (!mode_s && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      shift_d = '0;
      cnt_d   = '0;
      oe_d    = 1'b0;
      dout_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mode_s) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (clk_fall) begin
            shift_d = nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
              cnt_d = '0;
              case (cmd)
                CMD_LOAD: state_d = ST_LOAD_DATA;
                CMD_READ: begin
                  state_d = ST_READ_FETCH;
                  rd_en_d = 1'b1;
                end
                CMD_INCR: addr_d = addr_q + ADDR_WIDTH'(1);
                CMD_PROG: begin
                  state_d   = ST_PROG;
                  wr_en_d   = 1'b1;
                  wr_data_d = latch_q;
                  busy_d    = 1'b1;
                end
                CMD_RESET_ADDR: addr_d = '0;
`ifdef ICSP_BULK_ERASE_EN
                CMD_BULK_ERASE: begin
                  state_d   = ST_ERASE;
                  addr_d    = '0;
                  wr_en_d   = 1'b1;
                  wr_data_d = DATA_WIDTH'(ERASE_FILL);
                  busy_d    = 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        ST_LOAD_DATA: begin
          if (clk_fall) begin
            shift_d = nxt;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              latch_d = nxt[DATA_WIDTH:1];
              cnt_d   = '0;
              state_d = ST_CMD;
            end
          end
        end
        ST_READ_FETCH: state_d = ST_READ_CAPTURE;
        ST_READ_CAPTURE: begin
          shift_d = {1'b0, pm_rd_data, 1'b0};
          oe_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_READ_SHIFT;
        end
        ST_READ_SHIFT: begin
          if (clk_rise) begin
            dout_d  = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (clk_fall) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              cnt_d   = '0;
              oe_d    = 1'b0;
              dout_d  = 1'b0;
              state_d = ST_CMD;
            end
          end
        end
        ST_PROG: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PROG_CYCLES - 1)) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_CMD;
          end
        end
`ifdef ICSP_BULK_ERASE_EN
        ST_ERASE: begin
          if (addr_q == '1) begin
            addr_d  = '0;
            busy_d  = 1'b0;
            state_d = ST_CMD;
          end else begin
            addr_d    = addr_q + ADDR_WIDTH'(1);
            wr_en_d   = 1'b1;
            wr_data_d = DATA_WIDTH'(ERASE_FILL);
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pm_addr      = addr_q;
  assign pm_wr_en     = wr_en_q;
  assign pm_wr_data   = wr_data_q;
  assign pm_rd_en     = rd_en_q;
  assign icsp_dat_out = dout_q;
  assign icsp_dat_oe  = oe_q;
  assign busy         = busy_q;
  assign core_hold    = hold_q;

endmodule

// File: tb/tb_icsp_program_loader.sv
// Directed bench for icsp_program_loader; a 4-bit-address copy
// shares the serial inputs to exercise address wrap cheaply.
module tb_icsp_program_loader;

  localparam int HP = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_mode = 1'b0;
  logic        icsp_clk = 1'b0;
  logic        icsp_dat = 1'b0;
  logic [13:0] rd_data = '0;

  logic        dat_out, dat_oe, core_hold;
  logic [12:0] pm_addr;
  logic        pm_wr_en, pm_rd_en, busy;
  logic [13:0] pm_wr_data;

  logic        s_dat_out, s_dat_oe, s_hold;
  logic [3:0]  s_addr;
  logic        s_wr_en, s_rd_en, s_busy;
  logic [13:0] s_wr_data;

  int checks = 0;
  int failures = 0;

  int          wr_cnt = 0, rd_cnt = 0, busy_cyc = 0, fill_cnt = 0;
  logic [12:0] last_wr_addr = '0, rd_addr = '0;
  logic [13:0] last_wr_data = '0;

  always #5 clk = ~clk;

  icsp_program_loader dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .icsp_clk(icsp_clk), .icsp_dat_in(icsp_dat),
    .icsp_dat_out(dat_out), .icsp_dat_oe(dat_oe),
    .core_hold(core_hold), .pm_addr(pm_addr),
    .pm_wr_en(pm_wr_en), .pm_wr_data(pm_wr_data),
    .pm_rd_en(pm_rd_en), .pm_rd_data(rd_data),
    .busy(busy)
  );

  icsp_program_loader #(.ADDR_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .icsp_clk(icsp_clk), .icsp_dat_in(icsp_dat),
    .icsp_dat_out(s_dat_out), .icsp_dat_oe(s_dat_oe),
    .core_hold(s_hold), .pm_addr(s_addr),
    .pm_wr_en(s_wr_en), .pm_wr_data(s_wr_data),
    .pm_rd_en(s_rd_en), .pm_rd_data(rd_data),
    .busy(s_busy)
  );

  always @(negedge clk) begin
    if (pm_wr_en) begin
      wr_cnt++;
      last_wr_addr = pm_addr;
      last_wr_data = pm_wr_data;
      if (pm_wr_data == 14'h3FFF) fill_cnt++;
    end
    if (pm_rd_en) begin
      rd_cnt++;
      rd_addr = pm_addr;
    end
    if (busy) busy_cyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      icsp_dat = v[i];
      @(negedge clk);
      icsp_clk = 1'b1;
      repeat (HP) @(negedge clk);
      icsp_clk = 1'b0;
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [5:0] c);
    send_bits({10'd0, c}, 6);
  endtask

  task automatic read_frame(output logic [15:0] r, output int oe_hi);
    r = '0;
    oe_hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      icsp_clk = 1'b1;
      repeat (HP) @(negedge clk);
      r[i] = dat_out;
      if (dat_oe) oe_hi++;
      icsp_clk = 1'b0;
      repeat (HP) @(negedge clk);
    end
  endtask

  task automatic clr_mon();
    wr_cnt = 0;
    rd_cnt = 0;
    busy_cyc = 0;
    fill_cnt = 0;
  endtask

  logic [15:0] rx;
  int          oe_hi;
  int          waited;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_core_hold", core_hold, 0);
    chk("rst_pm_addr", pm_addr, 0);
    chk("rst_wr_en", pm_wr_en, 0);
    chk("rst_wr_data", pm_wr_data, 0);
    chk("rst_rd_en", pm_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oe", dat_oe, 0);
    chk("rst_dat_out", dat_out, 0);

    prog_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_after_sync", core_hold, 1);
    repeat (3) @(negedge clk);

    send_cmd(6'h16);
    send_cmd(6'h02);
    send_bits({1'b0, 14'h1ABC, 1'b0}, 16);
    clr_mon();
    send_cmd(6'h08);
    repeat (30) @(negedge clk);
    chk("prog_wr_count", wr_cnt, 1);
    chk("prog_wr_addr", last_wr_addr, 13'h0000);
    chk("prog_wr_data", last_wr_data, 14'h1ABC);
    chk("prog_busy_cycles", busy_cyc, 16);
    chk("prog_busy_end", busy, 0);
    chk("prog_no_incr", pm_addr, 0);

    repeat (3) send_cmd(6'h06);
    chk("incr3_addr", pm_addr, 3);
    rd_data = 14'h2345;
    clr_mon();
    send_cmd(6'h04);
    chk("read_oe_before", dat_oe, 1);
    read_frame(rx, oe_hi);
    chk("read_rd_count", rd_cnt, 1);
    chk("read_rd_addr", rd_addr, 3);
    chk("read_serial", rx, 16'h468A);
    chk("read_oe_high", oe_hi, 16);
    chk("read_oe_after", dat_oe, 0);
    chk("read_no_write", wr_cnt, 0);

    repeat (12) send_cmd(6'h06);
    chk("small_addr_max", s_addr, 4'hF);
    chk("addr_15", pm_addr, 15);
    send_cmd(6'h06);
    chk("small_addr_wrap", s_addr, 4'h0);
    chk("addr_16", pm_addr, 16);

    clr_mon();
    send_cmd(6'h3F);
    send_cmd(6'h06);
    chk("unk_no_wr", wr_cnt, 0);
    chk("unk_no_rd", rd_cnt, 0);
    chk("unk_then_incr", pm_addr, 17);

    clr_mon();
    send_cmd(6'h02);
    send_bits(16'h00FE, 8);
    prog_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_hold", core_hold, 0);
    chk("abort_addr", pm_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_oe", dat_oe, 0);
    chk("abort_no_wr", wr_cnt, 0);
    icsp_dat = 1'b0;
    prog_mode = 1'b1;
    repeat (6) @(negedge clk);
    send_cmd(6'h08);
    repeat (30) @(negedge clk);
    chk("resume_wr_count", wr_cnt, 1);
    chk("resume_wr_addr", last_wr_addr, 0);
    chk("resume_latch", last_wr_data, 14'h1ABC);

    send_cmd(6'h06);
    chk("pre_erase_addr", pm_addr, 1);
    clr_mon();
    send_cmd(6'h09);
    repeat (10) @(negedge clk);
    waited = 0;
    while (busy && waited < 9000) begin
      @(negedge clk);
      waited++;
    end
    chk("erase_timeout", busy, 0);
    repeat (4) @(negedge clk);
`ifdef ICSP_BULK_ERASE_EN
    chk("erase_wr_count", wr_cnt, 8192);
    chk("erase_fill_count", fill_cnt, 8192);
    chk("erase_busy_cycles", busy_cyc, 8192);
    chk("erase_last_addr", last_wr_addr, 13'h1FFF);
    chk("erase_final_addr", pm_addr, 0);
`else
    chk("erase_wr_count", wr_cnt, 0);
    chk("erase_busy_cycles", busy_cyc, 0);
    chk("erase_final_addr", pm_addr, 1);
`endif
    send_cmd(6'h06);
`ifdef ICSP_BULK_ERASE_EN
    chk("post_erase_incr", pm_addr, 1);
`else
    chk("post_erase_incr", pm_addr, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icsp_program_loader.md
Name: icsp_program_loader

Overview:
- Serial in-circuit programming (ICSP) responder; the write/readback side of the program memory the core fetches from.
- Decodes 6-bit commands and 16-bit data frames clocked in on icsp_clk/icsp_dat, then drives the program memory write/read port.
- Holds the core in reset while programming mode is active.
- Lives beside program_memory; arbitration gives it the memory port whenever core_hold=1.

Parameters:
- ADDR_WIDTH, 13, program memory address width
- DATA_WIDTH, 14, instruction word width
- SYNC_STAGES, 2, synchroniser depth on icsp_clk/icsp_dat_in/prog_mode
- PROG_CYCLES, 16, clk cycles the block stays busy after a program-memory write

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- prog_mode  in  1  programming-mode request (async; MCLR-derived)
- icsp_clk  in  1  serial clock (async)
- icsp_dat_in  in  1  serial data from programmer (async)
- icsp_dat_out  out  1  serial readback data
- icsp_dat_oe  out  1  readback output enable
- core_hold  out  1  holds the core in reset while high
- pm_addr  out  ADDR_WIDTH  program memory address
- pm_wr_en  out  1  one-cycle write strobe
- pm_wr_data  out  DATA_WIDTH  write data
- pm_rd_en  out  1  one-cycle read strobe
- pm_rd_data  in  DATA_WIDTH  read data, valid the cycle after pm_rd_en
- busy  out  1  write or erase in progress

Behaviour:
- Reset values: all outputs 0, address counter 0, data latch 0, state IDLE.
- Synchronising and edge detection:
  - prog_mode, icsp_clk and icsp_dat_in pass through SYNC_STAGES flops.
  - Rise/fall of icsp_clk is detected on the synchronised signal (one-clk pulses).
  - icsp_clk high and low phases must each last at least SYNC_STAGES+2 clk.
- core_hold is the registered synchronised prog_mode.
- Framing:
  - Bits are LSB first, sampled on icsp_clk falling edge.
  - A command is 6 bits. A data frame is 16 bits: start(0), 14 data, stop(0).
  - Start and stop bits are ignored on input.
- States:
  - IDLE: leaves for CMD when synced prog_mode=1.
  - CMD: shifts in 6 bits, then decodes:
    - 0x02 LOAD -> LOAD_DATA
    - 0x04 READ -> READ_FETCH
    - 0x06 INCR: address+1, wraps 0x1FFF->0x0000, back to CMD
    - 0x08 PROGRAM -> PROG
    - 0x16 RESET_ADDR: address=0, back to CMD
    - any other code: ignored, back to CMD
  - LOAD_DATA: shifts 16 bits; data latch = bits[14:1]; back to CMD.
  - READ_FETCH: pm_rd_en=1 for one clk; pm_rd_data captured the next clk into the shift register framed as {0, data, 0} -> READ_SHIFT.
  - READ_SHIFT:
    - icsp_dat_oe=1 for the whole state.
    - Each icsp_clk rising edge drives the next bit on icsp_dat_out (the first rise drives the start bit).
    - After the 16th falling edge: oe=0 -> CMD.
  - PROG:
    - pm_wr_en=1 for exactly one clk with pm_addr=address and pm_wr_data=latch.
    - busy=1 from the write clk through PROG_CYCLES clk, then -> CMD.
    - icsp_clk edges are ignored while busy; the address does not auto-increment.
- pm_addr always reflects the address counter.
- Abort: synced prog_mode falling in any state -> IDLE next clk.
  - Outputs go to reset values and the address clears.
  - A pending write strobe that already fired is not retracted.
- Async rst mid-frame: immediate return to reset values; partial frames are discarded.

Optional Feature:
- Macro ICSP_BULK_ERASE_EN.
- With the macro:
  - Command 0x09 BULK_ERASE enters ERASE, with busy=1.
  - Writes 0x3FFF to addresses 0 to 2^ADDR_WIDTH-1, one write per clk.
  - The address counter is restored to 0, then -> CMD.
  - prog_mode abort stops the erase immediately.
- Without the macro: 0x09 is treated as an unknown command (ignored). No ERASE state is generated.

Decomposition:
- Shared package: command opcodes, state enumeration, frame lengths (6/16), erase fill constant 0x3FFF.
- One natural sub-module, icsp_sync_edge: synchroniser plus rise/fall pulse generator, instantiated for icsp_clk and reused (edge outputs unused) for icsp_dat_in and prog_mode.

Test Plan:
- Reset with prog_mode=0 -> core_hold=0, all pm_* outputs 0; raise prog_mode -> core_hold=1 within SYNC_STAGES+1 clk.
- RESET_ADDR, LOAD 0x1ABC, PROGRAM -> single pm_wr_en pulse with pm_addr=0x0000, pm_wr_data=0x1ABC; busy high for 16 clk.
- INCR x3, then READ with pm_rd_data=0x2345 -> pm_rd_en once at addr 3; icsp_dat_out serialises 0,0x2345 LSB-first,0 with oe high for exactly 16 clocks.
- Address 0x1FFF, INCR -> pm_addr=0x0000; unknown command 0x3F -> no pm strobe and the next command decodes normally.
- Drop prog_mode after 8 bits of a LOAD frame -> IDLE, address 0, latch unchanged, no write; the next session starts clean.
- With ICSP_BULK_ERASE_EN: command 0x09 -> 8192 consecutive writes of 0x3FFF, busy high throughout, final pm_addr=0. Without the macro: no writes.
